// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first,
//   one bit per clock through a single full-subtractor cell and a borrow flop.
//   Build option: define SUB_OVF_EN to add the signed-overflow output 'ovf'.
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, sampled only in IDLE
//   a      in   WIDTH  minuend, captured on accepted start
//   b      in   WIDTH  subtrahend, captured on accepted start
//   bin    in   1      borrow-in, captured on accepted start
//   busy   out  1      high in RUN and DONE (registered)
//   done   out  1      one-cycle result-valid pulse
//   diff   out  WIDTH  registered difference
//   bout   out  1      final borrow-out (unsigned a < b+bin)
//   ovf    out  1      signed overflow (SUB_OVF_EN only)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0]    count;
  logic             brw;
  logic             d, brw_nxt, last;

  // full-subtractor cell on the current LSBs
  always_comb begin
    d       = sa[0] ^ sb[0] ^ brw;
    brw_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
    last    = (count == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign done = (state == DONE);

`ifdef SUB_OVF_EN
  // operand signs are captured at start since sa/sb are consumed by shifting
  logic a_msb, b_msb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      count <= '0;
      brw   <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN) || (state_nxt == DONE);
      case (state)
        IDLE: if (start) begin
          sa    <= a;
          sb    <= b;
          brw   <= bin;
          count <= '0;
`ifdef SUB_OVF_EN
          a_msb <= a[WIDTH-1];
          b_msb <= b[WIDTH-1];
`endif
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          brw   <= brw_nxt;
          res   <= {d, res[WIDTH-1:1]};
          count <= count + 1'b1;
          if (last) begin
            diff <= {d, res[WIDTH-1:1]};
            bout <= brw_nxt;
`ifdef SUB_OVF_EN
            // d is the result MSB on the final bit; bin does not enter the sign test
            ovf  <= (a_msb != b_msb) && (d != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
`ifdef SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // apply one operation; lat = negedges from the start cycle to the done cycle
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bi, output int lat);
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; bin = $urandom;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, npulse;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif

    // 10-3
    run_op(8'd10, 8'd3, 1'b0, lat);
    chk("lat_10m3", lat, 9);
    chk("diff_10m3", diff, 8'h07);
    chk("bout_10m3", bout, 0);
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);

    // 3-10
    run_op(8'd3, 8'd10, 1'b0, lat);
    chk("lat_3m10", lat, 9);
    chk("diff_3m10", diff, 8'hF9);
    chk("bout_3m10", bout, 1);

    // 0-0-1 wraps
    run_op(8'd0, 8'd0, 1'b1, lat);
    chk("diff_wrap", diff, 8'hFF);
    chk("bout_wrap", bout, 1);

    // 0x55-0x11 with a stray start mid-RUN
    @(negedge clk);
    a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("diff_hold_on_start", diff, 8'hFF);
    repeat (2) @(negedge clk);
    a = 8'hF0; b = 8'h01; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    npulse = 0;
    for (int i = 0; i < 14; i++) begin
      if (done) begin
        npulse++;
        chk("diff_55m11", diff, 8'h44);
      end
      @(negedge clk);
    end
    chk("single_done", npulse, 1);
    chk("idle_after_ign", busy, 0);

    // next start in IDLE is accepted
    run_op(8'h10, 8'h20, 1'b0, lat);
    chk("lat_10m20", lat, 9);
    chk("diff_10m20", diff, 8'hF0);
    chk("bout_10m20", bout, 1);

    // reset mid-RUN of 200-100
    @(negedge clk);
    a = 8'd200; b = 8'd100; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_diff", diff, 0);
    chk("rst_mid_bout", bout, 0);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) npulse++;
      @(negedge clk);
    end
    chk("rst_mid_nodone", npulse, 0);

    run_op(8'd9, 8'd9, 1'b0, lat);
    chk("lat_9m9", lat, 9);
    chk("diff_9m9", diff, 8'h00);
    chk("bout_9m9", bout, 0);

`ifdef SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0, lat);
    chk("diff_80m01", diff, 8'h7F);
    chk("ovf_80m01", ovf, 1);
    chk("bout_80m01", bout, 0);
    run_op(8'h05, 8'h03, 1'b0, lat);
    chk("diff_05m03", diff, 8'h02);
    chk("ovf_05m03", ovf, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
